// File: rtl/axis_chan_align_pkg.sv
// Shared types, constants and helpers for the channel aligner (package ty_axis_pkg).
package ty_axis_pkg;

    localparam int TY_DATA_WIDTH   = 512;
    localparam int TY_NUM_CHANNELS = 2;
    localparam int TY_FIFO_DEPTH   = 16;

    localparam int PTR_W = $clog2(TY_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [TY_DATA_WIDTH-1:0] ty_word_t;

    // FIFO_RESET keeps the FIFO closed (not ready, not valid) until the first clean edge.
    typedef enum logic [1:0] {
        FIFO_RESET,
        FIFO_IDLE,
        FIFO_PARTIAL,
        FIFO_FULL
    } fifo_state_t;

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/axis_chan_align_if.sv
// Bundle of per-channel AXI4-Stream inputs and the aligned output stream.
interface axis_chan_align_if
    import ty_axis_pkg::*;
#(
    parameter int C_DATA_WIDTH   = TY_DATA_WIDTH,
    parameter int C_NUM_CHANNELS = TY_NUM_CHANNELS
);

    logic [C_NUM_CHANNELS-1:0]                   s_tvalid;
    logic [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0] s_tdata;
    logic [C_NUM_CHANNELS-1:0]                   s_tready;
    logic                                        m_tvalid;
    logic [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0] m_tdata;
    logic                                        m_tready;

    // slave: the aligner's view; master: the surrounding producer/consumer.
    modport slave (
        input  s_tvalid, s_tdata, m_tready,
        output s_tready, m_tvalid, m_tdata
    );

    modport master (
        output s_tvalid, s_tdata, m_tready,
        input  s_tready, m_tvalid, m_tdata
    );

endinterface

// File: rtl/axis_align_fifo.sv
// Synchronous first-word-fall-through FIFO for one aligner channel.
module axis_align_fifo
    import ty_axis_pkg::*;
#(
    parameter int C_DATA_WIDTH = TY_DATA_WIDTH,
    parameter int C_FIFO_DEPTH = TY_FIFO_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_i,
    input  logic [C_DATA_WIDTH-1:0] din_i,
    input  logic                    pop_i,
    output logic [C_DATA_WIDTH-1:0] dout_o,
    output logic                    full_o,
    output logic                    empty_o
);

    localparam int AW = $clog2(C_FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [C_DATA_WIDTH-1:0] mem_q [C_FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr_q;
    logic [AW-1:0]           rd_ptr_q;
    logic [CW-1:0]           count_q;
    logic [CW-1:0]           count_d;
    fifo_state_t             state_q;
    fifo_state_t             state_d;
    logic                    do_push;
    logic                    do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        state_d = FIFO_IDLE;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
        if (count_d == CW'(C_FIFO_DEPTH)) begin
            state_d = FIFO_FULL;
        end else if (count_d != '0) begin
            state_d = FIFO_PARTIAL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FIFO_RESET;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    // Flags decode straight from the state register; the reset state reads as full and empty.
    assign full_o  = (state_q == FIFO_FULL) || (state_q == FIFO_RESET);
    assign empty_o = (state_q == FIFO_IDLE) || (state_q == FIFO_RESET);
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/axis_chan_align.sv
// Lock-steps C_NUM_CHANNELS AXI4-Stream inputs into one bundle through per-channel FIFOs.
// Optional stall/starve counters are built when TY_ALIGN_STATS_EN is defined.
module axis_chan_align
    import ty_axis_pkg::*;
#(
    parameter int C_DATA_WIDTH   = TY_DATA_WIDTH,
    parameter int C_NUM_CHANNELS = TY_NUM_CHANNELS,
    parameter int C_FIFO_DEPTH   = TY_FIFO_DEPTH
) (
    input  logic              aclk,
    input  logic              areset,
    axis_chan_align_if.slave  bus
`ifdef TY_ALIGN_STATS_EN
    ,
    output logic [31:0]       stat_stall_cnt,
    output logic [31:0]       stat_starve_cnt
`endif
);

    if (C_NUM_CHANNELS < 1 || C_NUM_CHANNELS > 8) begin : g_bad_nch
        $error("axis_chan_align: C_NUM_CHANNELS must be in 1..8");
    end
    if (!is_pow2(C_FIFO_DEPTH) || C_FIFO_DEPTH < 2) begin : g_bad_depth
        $error("axis_chan_align: C_FIFO_DEPTH must be a power of 2 and >= 2");
    end

    logic [C_NUM_CHANNELS-1:0]                   fifo_full;
    logic [C_NUM_CHANNELS-1:0]                   fifo_empty;
    logic [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0] fifo_head;
    logic                                        pop_all;

    assign bus.m_tvalid = &(~fifo_empty);
    assign pop_all      = bus.m_tvalid && bus.m_tready;
    assign bus.s_tready = ~fifo_full;
    assign bus.m_tdata  = fifo_head;

    for (genvar i = 0; i < C_NUM_CHANNELS; i++) begin : g_chan
        axis_align_fifo #(
            .C_DATA_WIDTH (C_DATA_WIDTH),
            .C_FIFO_DEPTH (C_FIFO_DEPTH)
        ) u_fifo (
            .clk     (aclk),
            .rst     (areset),
            .push_i  (bus.s_tvalid[i]),
            .din_i   (bus.s_tdata[i]),
            .pop_i   (pop_all),
            .dout_o  (fifo_head[i]),
            .full_o  (fifo_full[i]),
            .empty_o (fifo_empty[i])
        );
    end

`ifdef TY_ALIGN_STATS_EN
    logic [31:0] stall_q;
    logic [31:0] starve_q;
    logic        any_data;

    assign any_data = |(~fifo_empty);

    always_ff @(posedge aclk) begin
        if (areset) begin
            stall_q  <= '0;
            starve_q <= '0;
        end else begin
            if (bus.m_tvalid && !bus.m_tready && stall_q != '1) begin
                stall_q <= stall_q + 32'd1;
            end
            if (any_data && !bus.m_tvalid && starve_q != '1) begin
                starve_q <= starve_q + 32'd1;
            end
        end
    end

    assign stat_stall_cnt  = stall_q;
    assign stat_starve_cnt = starve_q;
`endif

endmodule

// File: tb/tb_axis_chan_align.sv
// Randomized bench for axis_chan_align against a queue-based reference model.
module tb_axis_chan_align;
    import ty_axis_pkg::*;

    localparam int NCH   = 2;
    localparam int W     = 512;
    localparam int DEPTH = 16;

    typedef logic [NCH-1:0][W-1:0] bundle_t;

    logic aclk = 1'b0;
    logic areset;
    always #5 aclk = ~aclk;

    axis_chan_align_if #(.C_DATA_WIDTH(W), .C_NUM_CHANNELS(NCH)) bus ();

`ifdef TY_ALIGN_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] starve_cnt;
`endif

    axis_chan_align #(
        .C_DATA_WIDTH   (W),
        .C_NUM_CHANNELS (NCH),
        .C_FIFO_DEPTH   (DEPTH)
    ) dut (
        .aclk            (aclk),
        .areset          (areset),
        .bus             (bus)
`ifdef TY_ALIGN_STATS_EN
        ,
        .stat_stall_cnt  (stall_cnt),
        .stat_starve_cnt (starve_cnt)
`endif
    );

    ty_word_t q [NCH][$];
    bit       rdy_en = 1'b0;
    int       n_checks = 0;
    int       n_fail = 0;
    int       dut_bundles = 0;
    int       pushed [NCH];
    longint   m_stall = 0;
    longint   m_starve = 0;

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic ty_word_t rand_word();
        ty_word_t w;
        for (int j = 0; j < W / 32; j++) w[j*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic bit all_nonempty();
        for (int i = 0; i < NCH; i++) if (q[i].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit any_nonempty();
        for (int i = 0; i < NCH; i++) if (q[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_outputs();
        bit exp_v;
        exp_v = all_nonempty();
        for (int i = 0; i < NCH; i++) begin
            check_val($sformatf("s_tready[%0d]", i), W'(bus.s_tready[i]),
                      W'(rdy_en && q[i].size() < DEPTH));
        end
        check_val("m_tvalid", W'(bus.m_tvalid), W'(exp_v));
        if (exp_v) begin
            for (int i = 0; i < NCH; i++)
                check_val($sformatf("m_tdata[%0d]", i), bus.m_tdata[i], q[i][0]);
        end
`ifdef TY_ALIGN_STATS_EN
        check_val("stall_cnt", W'(stall_cnt), W'(m_stall));
        check_val("starve_cnt", W'(starve_cnt), W'(m_starve));
`endif
    endtask

    // One clock: drive inputs, advance the model by the transfers this edge takes, then compare.
    task automatic step(input logic rst, input logic [NCH-1:0] vld, input bundle_t d, input logic mrdy);
        logic [NCH-1:0] push;
        logic           pop;
        areset       = rst;
        bus.s_tvalid = vld;
        bus.s_tdata  = d;
        bus.m_tready = mrdy;
        for (int i = 0; i < NCH; i++) push[i] = !rst && rdy_en && vld[i] && (q[i].size() < DEPTH);
        pop = !rst && all_nonempty() && mrdy;
        if (!rst && bus.m_tvalid === 1'b1 && mrdy) dut_bundles++;
        if (rst) begin
            m_stall  = 0;
            m_starve = 0;
        end else begin
            if (all_nonempty() && !mrdy) m_stall++;
            if (any_nonempty() && !all_nonempty()) m_starve++;
        end
        @(posedge aclk);
        #1;
        if (rst) begin
            for (int i = 0; i < NCH; i++) q[i].delete();
            rdy_en = 1'b0;
        end else begin
            if (pop) for (int i = 0; i < NCH; i++) void'(q[i].pop_front());
            for (int i = 0; i < NCH; i++) if (push[i]) begin
                q[i].push_back(d[i]);
                pushed[i]++;
            end
            rdy_en = 1'b1;
        end
        check_outputs();
    endtask

    initial begin
        bundle_t d;
        bundle_t first;
        int      b0;
        for (int i = 0; i < NCH; i++) pushed[i] = 0;

        // Reset held for three cycles with both channels offering data.
        d = '0;
        d[0] = rand_word();
        d[1] = rand_word();
        repeat (3) step(1'b1, 2'b11, d, 1'b0);
        for (int i = 0; i < NCH; i++)
            check_val($sformatf("rst_tdata[%0d]", i), bus.m_tdata[i], '0);
        step(1'b0, 2'b00, '0, 1'b0);

        // Aligned stream, 32 bundles.
        b0 = dut_bundles;
        for (int k = 0; k < 32; k++) begin
            d = '0;
            d[0] = W'(32'h1 + k);
            d[1] = W'(32'h101 + k);
            step(1'b0, 2'b11, d, 1'b1);
            if (k == 0) begin
                check_val("first_ch0", bus.m_tdata[0], W'(32'h1));
                check_val("first_ch1", bus.m_tdata[1], W'(32'h101));
            end
        end
        repeat (2) step(1'b0, 2'b00, '0, 1'b1);
        check_val("aligned_bundles", W'(dut_bundles - b0), W'(32));

        // Skew: ch0 runs 16 words (plus one refused) ahead of ch1.
        for (int k = 0; k < 17; k++) begin
            d = '0;
            d[0] = rand_word();
            step(1'b0, 2'b01, d, 1'b1);
        end
        check_val("skew_ready0", W'(bus.s_tready[0]), W'(0));
        for (int k = 0; k < 16; k++) begin
            d = '0;
            d[1] = rand_word();
            step(1'b0, 2'b10, d, 1'b1);
        end
        repeat (2) step(1'b0, 2'b00, '0, 1'b1);

        // Backpressure: fill both FIFOs, hold m_tready low, then drain.
        for (int k = 0; k < DEPTH; k++) begin
            d[0] = rand_word();
            d[1] = rand_word();
            if (k == 0) first = d;
            step(1'b0, 2'b11, d, 1'b0);
        end
        for (int k = 0; k < 10; k++) begin
            d[0] = rand_word();
            d[1] = rand_word();
            step(1'b0, 2'b11, d, 1'b0);
            for (int i = 0; i < NCH; i++)
                check_val($sformatf("bp_hold[%0d]", i), bus.m_tdata[i], first[i]);
        end
        b0 = dut_bundles;
        repeat (DEPTH) step(1'b0, 2'b00, '0, 1'b1);
        step(1'b0, 2'b00, '0, 1'b1);
        check_val("bp_drain", W'(dut_bundles - b0), W'(DEPTH));

        // Random valid/ready across pointer wrap until each channel has pushed 100 more words.
        for (int i = 0; i < NCH; i++) pushed[i] = 0;
        for (int c = 0; c < 3000 && (pushed[0] < 100 || pushed[1] < 100); c++) begin
            d[0] = rand_word();
            d[1] = rand_word();
            step(1'b0, NCH'($urandom_range(0, 3)), d, 1'($urandom_range(0, 1)));
        end
        check_val("rand_progress", W'(pushed[0] >= 100 && pushed[1] >= 100), W'(1));

        // Reset with words still buffered discards them.
        step(1'b1, 2'b11, d, 1'b1);
        step(1'b0, 2'b00, '0, 1'b1);
        step(1'b0, 2'b00, '0, 1'b1);

`ifdef TY_ALIGN_STATS_EN
        d[0] = rand_word();
        d[1] = rand_word();
        step(1'b0, 2'b11, d, 1'b0);
        repeat (5) step(1'b0, 2'b00, '0, 1'b0);
        check_val("stat_stall5", W'(stall_cnt), W'(5));
        step(1'b1, 2'b00, '0, 1'b0);
        check_val("stat_stall_rst", W'(stall_cnt), W'(0));
        step(1'b0, 2'b00, '0, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
